// File: rtl/npu_definitions.sv
// Shared NPU constants: local buffer geometry, requester count/indices and
// the arbiter lock-state encoding.
package npu_definitions;

    localparam int DATA_WIDTH    = 32;
    localparam int LB_ADDR_WIDTH = 10;
    localparam int LB_N_REQ      = 3;
    localparam int LB_MAX_LOCK   = 8;

    // Fixed requester slots on the local buffer arbiter
    localparam int LB_REQ_DMA = 0;
    localparam int LB_REQ_PE  = 1;
    localparam int LB_REQ_WB  = 2;

    typedef enum logic {
        LB_IDLE   = 1'b0,
        LB_LOCKED = 1'b1
    } lb_lock_state_e;

endpackage

// File: rtl/lb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Returns one-hot grant plus its encoded index.
module lb_rr_pick #(
    parameter int N    = 3,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = j;
                any      = 1'b1;
            end
            j = (j == IDXW'(N - 1)) ? '0 : j + IDXW'(1);
        end
    end

endmodule

// File: rtl/local_buffer_arbiter.sv
// Round-robin arbiter sharing one single-port local buffer among N_REQ requesters,
// with bounded lock bursts. Define LOCAL_BUFFER_ARB_PERF_EN to add perf counters.
module local_buffer_arbiter #(
    parameter int N_REQ      = npu_definitions::LB_N_REQ,
    parameter int DATA_WIDTH = npu_definitions::DATA_WIDTH,
    parameter int ADDR_WIDTH = npu_definitions::LB_ADDR_WIDTH,
    parameter int MAX_LOCK   = npu_definitions::LB_MAX_LOCK
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef LOCAL_BUFFER_ARB_PERF_EN
    input  logic                        perf_clr,
    output logic [N_REQ*32-1:0]         perf_grant_cnt,
    output logic [31:0]                 perf_conflict_cnt,
`endif
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ-1:0]            req_lock,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        buf_ce,
    output logic                        buf_we,
    output logic [ADDR_WIDTH-1:0]       buf_addr,
    output logic [DATA_WIDTH-1:0]       buf_wdata,
    input  logic [DATA_WIDTH-1:0]       buf_rdata
);
    import npu_definitions::*;

    localparam int IDXW = $clog2(N_REQ);
    localparam int CNTW = 8;

    lb_lock_state_e  state_reg, state_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [IDXW-1:0] owner_reg, owner_next;
    logic [CNTW-1:0] lock_cnt_reg, lock_cnt_next;
    logic            miss_reg, miss_next;
    logic [N_REQ-1:0] rsp_valid_reg;

    logic [N_REQ-1:0] pick_grant;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic             gnt_any;
    logic [IDXW-1:0]  gnt_idx;

    logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (i == IDXW'(N_REQ - 1)) ? '0 : i + IDXW'(1);
    endfunction

    lb_rr_pick #(
        .N    (N_REQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        lock_cnt_next = lock_cnt_reg;
        miss_next     = miss_reg;
        gnt_any       = 1'b0;
        gnt_idx       = pick_idx;
        req_ready     = '0;
        if (rst_n) begin
            case (state_reg)
                LB_IDLE: begin
                    if (pick_any) begin
                        gnt_any = 1'b1;
                        // A single-beat lock budget is spent on the entry beat itself
                        if (req_lock[pick_idx] && MAX_LOCK > 1) begin
                            state_next    = LB_LOCKED;
                            owner_next    = pick_idx;
                            lock_cnt_next = CNTW'(1);
                            miss_next     = 1'b0;
                        end else begin
                            ptr_next = next_idx(pick_idx);
                        end
                    end
                end
                LB_LOCKED: begin
                    gnt_idx = owner_reg;
                    if (req_valid[owner_reg]) begin
                        gnt_any   = 1'b1;
                        miss_next = 1'b0;
                        if (!req_lock[owner_reg] || lock_cnt_reg >= CNTW'(MAX_LOCK - 1)) begin
                            state_next    = LB_IDLE;
                            ptr_next      = next_idx(owner_reg);
                            lock_cnt_next = '0;
                        end else begin
                            lock_cnt_next = lock_cnt_reg + CNTW'(1);
                        end
                    end else if (miss_reg) begin
                        state_next    = LB_IDLE;
                        ptr_next      = next_idx(owner_reg);
                        lock_cnt_next = '0;
                        miss_next     = 1'b0;
                    end else begin
                        // First idle cycle of the owner: hold the bubble
                        miss_next = 1'b1;
                    end
                end
                default: state_next = LB_IDLE;
            endcase
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign buf_ce    = gnt_any;
    assign buf_we    = gnt_any & req_we[gnt_idx];
    assign buf_addr  = gnt_any ? addr_arr[gnt_idx]  : '0;
    assign buf_wdata = gnt_any ? wdata_arr[gnt_idx] : '0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = buf_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LB_IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            lock_cnt_reg  <= '0;
            miss_reg      <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            lock_cnt_reg  <= lock_cnt_next;
            miss_reg      <= miss_next;
            rsp_valid_reg <= req_ready & ~req_we;
        end
    end

`ifdef LOCAL_BUFFER_ARB_PERF_EN
    logic [31:0] conflict_cnt_reg;
    logic        multi_valid;

    assign multi_valid       = |(req_valid & (req_valid - N_REQ'(1)));
    assign perf_conflict_cnt = conflict_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               conflict_cnt_reg <= '0;
        else if (perf_clr)                        conflict_cnt_reg <= '0;
        else if (multi_valid && ~&conflict_cnt_reg) conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
            logic [31:0] grant_cnt_reg;
            assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        grant_cnt_reg <= '0;
                else if (perf_clr) grant_cnt_reg <= '0;
                else if (req_ready[gi] && req_valid[gi] && ~&grant_cnt_reg)
                    grant_cnt_reg <= grant_cnt_reg + 32'd1;
            end
        end
    endgenerate
`endif

endmodule

// File: doc/local_buffer_arbiter.md
Name: local_buffer_arbiter

Overview:
- Shares one single-port local_buffer instance among N_REQ requesters, for example a DMA fill port, a PE operand read port and a result writeback port.
- Accepts one single-beat read or write per cycle using round-robin arbitration.
- Supports optional bounded lock bursts.
- Routes each read response, which returns one cycle after grant, back to the requester that issued it.
- Sits between the requester ports and the buffer ce/we/addr/wdata/rdata pins.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 32, buffer word width; matches the shared definition.
- ADDR_WIDTH, 10, buffer address width (1024 words).
- MAX_LOCK, 8, maximum consecutive grants to a locked requester before forced rotation (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  requests continued ownership after this beat
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i
- req_wdata  in  N_REQ*DATA_WIDTH  flattened write data
- req_ready  out  N_REQ  one-hot grant; the beat is accepted when valid & ready
- rsp_valid  out  N_REQ  one-hot read-data-valid
- rsp_rdata  out  DATA_WIDTH  read data shared by all requesters; qualified by rsp_valid
- buf_ce  out  1  buffer chip enable
- buf_we  out  1  buffer write enable
- buf_addr  out  ADDR_WIDTH  buffer address
- buf_wdata  out  DATA_WIDTH  buffer write data
- buf_rdata  in  DATA_WIDTH  buffer registered read data

Behaviour:
- Reset (async) values:
  - req_ready = 0, rsp_valid = 0, buf_ce = 0, buf_we = 0.
  - buf_addr and buf_wdata are driven 0 while no grant is issued.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - lock_cnt = 0; owner = none.
- Grant logic:
  - Combinational from req_valid, the pointer and the lock state.
  - At most one req_ready bit is high per cycle.
  - req_ready is never high without the matching req_valid.
- Round-robin: search starts at index ptr and wraps modulo N_REQ. After a grant to i with no lock in effect, ptr <= (i+1) mod N_REQ.
- Buffer drive: in the grant cycle,
  - buf_ce = 1;
  - buf_we = req_we[i];
  - buf_addr = req_addr slice i;
  - buf_wdata = req_wdata slice i.
  All are combinational pass-through with zero added latency.
- Read response: a granted read sets rsp_valid[i] exactly 1 cycle later, with rsp_rdata = buf_rdata in that cycle. Back-to-back reads from different requesters pipeline at 1 beat per cycle.
- Writes generate no response.
- Lock state machine, states IDLE and LOCKED:
  - IDLE -> LOCKED: on a grant to i with req_lock[i] = 1. Owner <= i, lock_cnt <= 1.
  - LOCKED, req_valid[owner] = 1: grant goes to the owner only; lock_cnt increments.
  - LOCKED, owner's req_valid = 0 for one cycle: other requesters are not granted that cycle (hold bubble).
  - LOCKED -> IDLE when any of the following holds:
    - a granted owner beat has req_lock = 0;
    - lock_cnt reaches MAX_LOCK;
    - the owner's req_valid is low for 2 consecutive cycles.
  - On exit, ptr <= (owner+1) mod N_REQ.
  - A forced exit at MAX_LOCK ignores req_lock on that beat.
- No requester valid: no grant; buf_ce = 0; ptr unchanged.
- Simultaneous requests: exactly one grant per cycle; every persistently valid requester is granted within N_REQ cycles when no lock is active, and within N_REQ*MAX_LOCK worst case.
- Reset mid-operation: a pending response is dropped and rsp_valid is 0 from reset onward. Lock and pointer are cleared.
- Requesters hold valid, we, addr and wdata stable until ready; the arbiter does not check this.

Optional Feature:
- Macro: LOCAL_BUFFER_ARB_PERF_EN.
- With the macro defined, three extra outputs are present:
  - perf_grant_cnt (N_REQ*32): per-requester accepted-beat counters.
  - perf_conflict_cnt (32): counts cycles with 2 or more valids.
  - perf_clr (input, 1): synchronously zeroes all counters.
  - All counters saturate at all-ones and reset to 0.
- Without the macro: these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package/header (npu_definitions): DATA_WIDTH, LB_ADDR_WIDTH = 10, LB_N_REQ = 3, LB_MAX_LOCK = 8, and named requester indices LB_REQ_DMA = 0, LB_REQ_PE = 1, LB_REQ_WB = 2.
- One sub-module, lb_rr_pick:
  - Parameterised combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Lock, pointer and response registers stay in the parent.

Test Plan:
- Single read: reset, then requester 1 reads addr 0x005 (buffer preloaded with 0xA5A5_0005) -> req_ready[1] high the same cycle; buf_ce = 1, buf_we = 0; next cycle rsp_valid = 3'b010 and rsp_rdata = 0xA5A5_0005.
- Contention: all three requesters read continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2; rsp_valid follows one cycle behind with the same order.
- Write then read: requester 0 writes 0x1234_5678 to 0x3FF, then requester 2 reads 0x3FF -> rsp_valid[2] carries 0x1234_5678; no rsp_valid on the write.
- Lock burst: requester 0 holds lock with 12 valid beats while requester 1 is valid -> requester 0 gets 8 consecutive grants (MAX_LOCK), then requester 1 is granted, then requester 0 resumes.
- Lock release and bubble: owner 2 drops valid for 1 cycle -> no grant that cycle, then resumes. Owner 2 drops valid for 2 cycles -> exit to IDLE and requester 0 is granted on the 3rd cycle.
- Reset mid-read: assert rst_n low in the cycle after a read grant -> rsp_valid = 0 immediately and no stale response after reset release.
